cmd_parser: RTL and testbench

- Command-framing stage sitting directly upstream of the opcode decoder / control FSM.
- Consumes the byte stream from the UART receiver and assembles SUMP-protocol commands.
  - Short commands: 1 byte, opcode bit 7 = 0.
  - Long commands: 5 bytes, opcode bit 7 = 1, followed by 4 data bytes.
- Emits one opcode plus 32-bit argument per complete command, with a single-cycle valid strobe, to the decoder that matches against opcode_t.
- Aborts partially received long commands after an inter-byte timeout so a lost byte cannot desynchronise the stream.

---
 rtl/cmd_parser.sv | 120 ++++++++++++
 tb/tb_cmd_parser.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_parser.sv
// SUMP command framer: turns a UART byte stream into opcode + 32-bit argument strobes,
// discarding partially received long commands after an inter-byte timeout.
module cmd_parser #(
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int TMR_WIDTH      = 17
) (
    input  logic        clk_i,
    input  logic        rst_in,
    input  logic [7:0]  byte_i,
    input  logic        byte_valid_i,
    output logic        cmd_valid_o,
    output logic [7:0]  opcode_o,
    output logic [31:0] data_o,
    output logic        busy_o,
    output logic        err_timeout_o
);

    // Handshake: byte_valid_i qualifies byte_i for exactly one cycle; there is no ready,
    // so every strobed byte is consumed. cmd_valid_o / err_timeout_o are one-cycle pulses
    // and the consumer must take each command the cycle it is presented.

    typedef enum logic {
        IDLE = 1'b0,
        ARG  = 1'b1
    } state_t;

    localparam logic                 TMR_EN    = (TIMEOUT_CYCLES > 0);
    localparam logic [TMR_WIDTH-1:0] TMR_LIMIT = TMR_WIDTH'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [1:0]           r_cnt;
    logic [1:0]           w_cnt_nxt;
    logic [TMR_WIDTH-1:0] r_tmr;
    logic [TMR_WIDTH-1:0] w_tmr_nxt;
    logic [7:0]           r_opcode;
    logic [7:0]           w_opcode_nxt;
    logic [31:0]          r_data;
    logic [31:0]          w_data_nxt;
    logic                 r_cmd_valid;
    logic                 w_cmd_valid_nxt;
    logic                 r_err;
    logic                 w_err_nxt;
    logic                 w_tmr_limit;
    logic                 w_tmr_sat;

    assign w_tmr_limit = TMR_EN && (r_tmr == TMR_LIMIT);
    assign w_tmr_sat   = &r_tmr;

    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            r_state     <= IDLE;
            r_cnt       <= 2'd0;
            r_tmr       <= '0;
            r_opcode    <= 8'h00;
            r_data      <= 32'h0;
            r_cmd_valid <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_tmr       <= w_tmr_nxt;
            r_opcode    <= w_opcode_nxt;
            r_data      <= w_data_nxt;
            r_cmd_valid <= w_cmd_valid_nxt;
            r_err       <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_tmr_nxt       = r_tmr;
        w_opcode_nxt    = r_opcode;
        w_data_nxt      = r_data;
        w_cmd_valid_nxt = 1'b0;
        w_err_nxt       = 1'b0;
        case (r_state)
            IDLE: begin
                if (byte_valid_i) begin
                    w_opcode_nxt = byte_i;
                    w_data_nxt   = 32'h0;
                    if (byte_i[7]) begin
                        w_state_nxt = ARG;
                        w_cnt_nxt   = 2'd0;
                        w_tmr_nxt   = '0;
                    end else begin
                        w_cmd_valid_nxt = 1'b1;
                    end
                end
            end
            ARG: begin
                // A byte on the limit cycle wins over the timeout.
                if (byte_valid_i) begin
                    w_data_nxt[{r_cnt, 3'b000} +: 8] = byte_i;
                    w_cnt_nxt = r_cnt + 2'd1;
                    w_tmr_nxt = '0;
                    if (r_cnt == 2'd3) begin
                        w_cmd_valid_nxt = 1'b1;
                        w_state_nxt     = IDLE;
                    end
                end else if (w_tmr_limit) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = 2'd0;
                    w_tmr_nxt   = '0;
                end else if (!w_tmr_sat) begin
                    w_tmr_nxt = r_tmr + TMR_WIDTH'(1);
                end
            end
        endcase
    end

    assign cmd_valid_o   = r_cmd_valid;
    assign opcode_o      = r_opcode;
    assign data_o        = r_data;
    assign busy_o        = (r_state == ARG);
    assign err_timeout_o = r_err;

endmodule

// File: tb/tb_cmd_parser.sv
// Directed bench for cmd_parser: command-level reference model with per-cycle comparison,
// plus literal expectations for each scenario.
module tb_cmd_parser;

    localparam int TO = 20;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [7:0]  byte_in = 8'h00;
    logic        byte_valid = 1'b0;
    logic        cmd_valid;
    logic [7:0]  opcode;
    logic [31:0] data;
    logic        busy;
    logic        err;

    cmd_parser #(
        .TIMEOUT_CYCLES(TO),
        .TMR_WIDTH     (5)
    ) dut (
        .clk_i        (clk),
        .rst_in       (rst_n),
        .byte_i       (byte_in),
        .byte_valid_i (byte_valid),
        .cmd_valid_o  (cmd_valid),
        .opcode_o     (opcode),
        .data_o       (data),
        .busy_o       (busy),
        .err_timeout_o(err)
    );

    // clock / reset
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // reference model: a command is the pending bytes collected since the last opcode
    logic [39:0] exp_q[$];
    logic [7:0]  pend[$];
    int          cyc = 0;
    int          last_cyc = 0;
    logic        exp_valid = 1'b0;
    logic        exp_err = 1'b0;
    logic        exp_busy = 1'b0;

    always @(posedge clk) begin
        cyc++;
        exp_valid = 1'b0;
        exp_err   = 1'b0;
        if (!rst_n) begin
            pend.delete();
            exp_q.delete();
            exp_busy = 1'b0;
        end else begin
            if (pend.size() > 0 && !byte_valid && (cyc - last_cyc) >= TO) begin
                pend.delete();
                exp_err = 1'b1;
            end
            if (byte_valid) begin
                if (pend.size() == 0 && !byte_in[7]) begin
                    exp_q.push_back({byte_in, 32'h0});
                    exp_valid = 1'b1;
                end else begin
                    pend.push_back(byte_in);
                    if (pend.size() == 5) begin
                        exp_q.push_back({pend[0], pend[4], pend[3], pend[2], pend[1]});
                        exp_valid = 1'b1;
                        pend.delete();
                    end
                end
                last_cyc = cyc;
            end
            exp_busy = (pend.size() > 0);
        end
    end

    // scoreboard: compare every cycle on the falling edge
    int pulse_cnt = 0;
    int err_cnt = 0;
    int err_cyc = 0;
    int last_pulse_cyc = 0;
    int prev_pulse_cyc = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("reset_outs", {cmd_valid, err, busy, opcode, data}, 64'h0);
        end else begin
            chk("cmd_valid", cmd_valid, exp_valid);
            chk("err_timeout", err, exp_err);
            chk("busy", busy, exp_busy);
            if (err) begin
                err_cnt++;
                err_cyc = cyc;
            end
            if (cmd_valid) begin
                pulse_cnt++;
                prev_pulse_cyc = last_pulse_cyc;
                last_pulse_cyc = cyc;
                chk("cmd_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0)
                    chk("cmd_payload", {opcode, data}, exp_q.pop_front());
            end
        end
    end

    // driver tasks: called at posedge+1, each byte is held across exactly one posedge
    task automatic send(input logic [7:0] b);
        byte_in    = b;
        byte_valid = 1'b1;
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
        byte_in    = 8'h00;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_cmd(input string name, input logic [7:0] op, input logic [31:0] d);
        chk({name, "_valid"}, cmd_valid, 1'b1);
        chk({name, "_payload"}, {opcode, data}, {op, d});
    endtask

    int p0;
    int e0;
    int k;

    initial begin
        #1 rst_n = 1'b0;
        #19;
        chk("reset_literal", {cmd_valid, err, busy, opcode, data}, 64'h0);
        #13 rst_n = 1'b1;
        @(posedge clk);
        #1;
        idle(1);

        // short command, 1-cycle latency
        send(8'h01);
        check_cmd("short_01", 8'h01, 32'h0);
        idle(2);

        // long command, bytes 10 cycles apart
        p0 = pulse_cnt;
        send(8'hC0);
        chk("long_busy_after_op", busy, 1'b1);
        idle(9);
        send(8'h78); idle(9);
        send(8'h56); idle(9);
        send(8'h34); idle(9);
        chk("long_no_early_pulse", pulse_cnt - p0, 0);
        chk("long_busy_before_last", busy, 1'b1);
        send(8'h12);
        check_cmd("long_c0", 8'hC0, 32'h12345678);
        chk("long_busy_at_strobe", busy, 1'b0);
        idle(1);
        chk("long_pulse_count", pulse_cnt - p0, 1);
        idle(2);

        // back-to-back commands
        p0 = pulse_cnt;
        send(8'h02);
        check_cmd("b2b_short", 8'h02, 32'h0);
        send(8'h80);
        send(8'h04);
        send(8'h00);
        send(8'h00);
        send(8'h00);
        check_cmd("b2b_long", 8'h80, 32'h00000004);
        idle(1);
        chk("b2b_pulse_count", pulse_cnt - p0, 2);
        chk("b2b_spacing", last_pulse_cyc - prev_pulse_cyc, 5);
        idle(2);

        // timeout discards partial command
        p0 = pulse_cnt;
        e0 = err_cnt;
        send(8'h82);
        send(8'hAA);
        k = cyc;
        idle(25);
        chk("to_err_count", err_cnt - e0, 1);
        chk("to_err_timing", err_cyc - k, TO);
        chk("to_no_pulse", pulse_cnt - p0, 0);
        chk("to_busy_dropped", busy, 1'b0);
        send(8'h00);
        check_cmd("to_then_short", 8'h00, 32'h0);
        idle(2);

        // byte exactly on the limit cycle is accepted
        e0 = err_cnt;
        send(8'h83);
        send(8'h01);
        idle(TO - 1);
        send(8'h02);
        send(8'h03);
        send(8'h04);
        check_cmd("edge_ok", 8'h83, 32'h04030201);
        chk("edge_ok_no_err", err_cnt - e0, 0);
        idle(2);

        // byte one cycle late: timeout first, byte becomes an opcode
        e0 = err_cnt;
        send(8'h84);
        send(8'h05);
        idle(TO);
        send(8'h06);
        check_cmd("edge_late", 8'h06, 32'h0);
        chk("edge_late_err", err_cnt - e0, 1);
        idle(2);

        // asynchronous reset mid-command
        send(8'hC1);
        send(8'hFF);
        chk("rst_busy_before", busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_clear", {cmd_valid, err, busy, opcode, data}, 64'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(1);
        send(8'hC1);
        send(8'h01);
        send(8'h02);
        send(8'h03);
        send(8'h04);
        check_cmd("after_rst", 8'hC1, 32'h04030201);

        // XON / XOFF are plain short commands
        send(8'h11);
        check_cmd("xon", 8'h11, 32'h0);
        send(8'h13);
        check_cmd("xoff", 8'h13, 32'h0);

        idle(3);
        chk("exp_q_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
